// File: rtl/dbus_decoder_if.sv
// dbus_decoder_if: master-side request/response and shared slave-side fan-out signals of the data bus
interface dbus_decoder_if;
  logic [31:0]  addrM;
  logic [31:0]  doutM;
  logic         stbM;
  logic         weM;
  logic [3:0]   dmM;
  logic [31:0]  dinM;
  logic         nakM;
  logic [31:0]  addrS;
  logic [31:0]  dinS;
  logic         weS;
  logic [3:0]   dmS;
  logic [3:0]   stbS;
  logic [127:0] doutS;
  logic [3:0]   nakS;
  modport slave (
    input  addrM, doutM, stbM, weM, dmM, doutS, nakS,
    output dinM, nakM, addrS, dinS, weS, dmS, stbS
  );
  modport master (
    output addrM, doutM, stbM, weM, dmM, doutS, nakS,
    input  dinM, nakM, addrS, dinS, weS, dmS, stbS
  );
endinterface

// File: rtl/dbus_decoder.sv
// dbus_decoder: four-slave base/mask address decoder with response steering, unmapped responder and nak watchdog
module dbus_decoder #(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] BASE1 = 32'h1000_0000,
  parameter logic [31:0] BASE2 = 32'h2000_0000,
  parameter logic [31:0] BASE3 = 32'h3000_0000,
  parameter logic [31:0] MASK0 = 32'hF000_0000,
  parameter logic [31:0] MASK1 = 32'hF000_0000,
  parameter logic [31:0] MASK2 = 32'hF000_0000,
  parameter logic [31:0] MASK3 = 32'hF000_0000,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_decoder_if.slave        bus,
  output logic                 errUnmapped,
  output logic                 errTimeout,
  output logic [15:0]          errCount
);
  localparam logic [2:0] NONE = 3'd4;
  localparam logic [3:0][31:0] BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [3:0][31:0] MASK = {MASK3, MASK2, MASK1, MASK0};
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  logic [2:0]  sel, resp_q, resp_d;
  logic [15:0] cnt_q, cnt_d, err_cnt_q, err_cnt_d;
  logic        unm_q, unm_d, raw_nak, abort, nak;
  always_comb begin
    sel = NONE;
    for (int i = 3; i >= 0; i--)
      if ((bus.addrM & MASK[i]) == (BASE[i] & MASK[i])) sel = 3'(i);
  end
  assign bus.addrS = bus.addrM;
  assign bus.dinS  = bus.doutM;
  assign bus.weS   = bus.weM;
  assign bus.dmS   = bus.dmM;
  always_comb begin
    bus.stbS = '0;
    if (bus.stbM && !sel[2]) bus.stbS[sel[1:0]] = 1'b1;
  end
  // A stale nak from a slave abandoned by the watchdog is ignored once respSel moves on.
  assign raw_nak = !resp_q[2] && bus.nakS[resp_q[1:0]];
  assign abort   = raw_nak && (TIMEOUT != 0) && (cnt_q == TMO);
  assign nak     = raw_nak && !abort;
  assign bus.nakM = nak;
  assign bus.dinM = abort ? TIMEOUT_RDATA : resp_q[2] ? UNMAPPED_RDATA : bus.doutS[32*resp_q[1:0] +: 32];
  assign errUnmapped = unm_q;
  assign errTimeout  = abort;
  assign errCount    = err_cnt_q;
  always_comb begin
    resp_d    = nak ? resp_q : (bus.stbM ? sel : NONE);
    unm_d     = !nak && bus.stbM && sel[2];
    cnt_d     = (!raw_nak || TIMEOUT == 0 || abort) ? 16'd0 : cnt_q + 16'd1;
    err_cnt_d = ((unm_q || abort) && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q    <= NONE;
      unm_q     <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      resp_q    <= resp_d;
      unm_q     <= unm_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
